count_step_arbiter: RTL and testbench
=====================================

// Module: count_step_arbiter
//
// PURPOSE
//  Shares the 2-bit up/down counter FSM between two requesters (A, B).
//  Each requester asks for a move of N steps in one direction.
//  The block grants the counter round-robin and drives its up_down control plus a per-step enable.
//  It keeps a 2-bit position mirror and pulses done when the move completes.
//  It sits between the control requesters and the counter instance.
//
// PARAMETERS
//  CNT_W  8  width of the step-count field of each request
//
// PORTS
//  clk      in   1      system clock, all logic on rising edge
//  reset    in   1      synchronous, active-high reset
//  req_a    in   1      requester A wants the counter; held until gnt_a
//  dir_a    in   1      A direction: 0 = count up, 1 = count down
//  steps_a  in   CNT_W  A step count (0 allowed)
//  gnt_a    out  1      one-cycle grant pulse to A
//  req_b    in   1      requester B, same rules as A
//  dir_b    in   1      B direction
//  steps_b  in   CNT_W  B step count
//  gnt_b    out  1      one-cycle grant pulse to B
//  up_down  out  1      to counter: latched direction of the active move
//  step     out  1      to counter: advance one state this cycle
//  busy     out  1      move in progress (RUN or DONE)
//  owner    out  1      current/last grantee: 0 = A, 1 = B
//  done     out  1      one-cycle pulse when a move finishes
//  pos      out  2      position mirror, 0..3
//
// BEHAVIOUR
//  - Reset (any cycle, including mid-move): the move is aborted.
//    - state = IDLE; prio = A.
//    - All outputs are 0; pos = 00; remaining = 0.
//    - No done is issued for the aborted move.
//  - States: IDLE, RUN, DONE.
//  - IDLE:
//    - At an edge where req_a or req_b = 1, pick the winner.
//      - Both requesting: the requester named by prio wins.
//      - One requesting: that requester wins.
//    - Latch the winner's dir and steps into dir_q and remaining.
//    - Set owner = winner; set prio = the other requester.
//    - steps != 0: next state RUN. steps == 0: next state DONE.
//  - gnt_x (registered):
//    - 1 for exactly the first cycle after leaving IDLE, i.e. the first RUN cycle or the DONE cycle.
//    - dir and steps are sampled only at the granting edge.
//    - A req dropped before grant is ignored.
//  - RUN:
//    - step = 1 and up_down = dir_q in every RUN cycle.
//    - At each edge: remaining -= 1; pos += 1 (dir_q = 0) or pos -= 1 (dir_q = 1), mod 4 (3->0 and 0->3 wrap).
//    - remaining == 1 at an edge: that is the last step; next state DONE.
//  - DONE: done = 1 for one cycle, step = 0, then IDLE.
//  - busy = 1 in RUN and DONE; 0 in IDLE.
//  - Latency for N >= 1:
//    - Request sampled at edge E.
//    - step high in cycles E+1 .. E+N.
//    - done in cycle E+N+1; IDLE in E+N+2.
//  - Latency for N == 0: gnt and done both high in cycle E+1; IDLE in E+2.
//  - New requests are never accepted outside IDLE. Requests that are held stay pending.
//  - up_down holds dir_q in DONE and IDLE. It is 0 only after reset.
//
// CONFIGURATION
//  - STEP_GAP_EN defined:
//    - RUN alternates step cycles with one idle GAP cycle (step = 0, pos/remaining unchanged).
//    - N steps take 2N-1 cycles; no gap after the last step.
//  - STEP_GAP_EN undefined: steps are back-to-back, one per cycle; the GAP state is not built.
//
// TESTING
//  - Move up: reset, then req_a, dir_a=0, steps_a=5.
//    - Expect gnt_a for 1 cycle and step high 5 consecutive cycles with up_down=0.
//    - pos goes 0,1,2,3,0,1; done once; busy low 2 cycles after the last step.
//  - Move down with wrap: dir_b=1, steps_b=3 from pos=0.
//    - Expect pos 3,2,1, owner=1, done pulse.
//  - Contention: both req high after reset, steps_a=2, steps_b=3, both held continuously.
//    - Expect grant order A, B, A.
//    - No cycle has gnt_a and gnt_b both high.
//    - No step in DONE/IDLE cycles.
//  - Zero steps: steps_a=0.
//    - Expect gnt_a and done in the same cycle, step never high, pos unchanged.
//  - Reset mid-move: steps_a=10, reset asserted after 4 steps.
//    - Expect step=0, busy=0, pos=0 the next cycle and no done.
//    - A fresh request afterwards is granted to A.
//  - STEP_GAP_EN build: steps_a=3.
//    - Expect step pattern 1,0,1,0,1, then done in the following cycle.

Source files
------------

// File: rtl/count_step_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | count_step_arbiter_if                                            |
// | Requester-side and counter-side signals of count_step_arbiter.   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
interface count_step_arbiter_if #(
    parameter int CNT_W = 8
);
    logic             req_a;
    logic             dir_a;
    logic [CNT_W-1:0] steps_a;
    logic             gnt_a;
    logic             req_b;
    logic             dir_b;
    logic [CNT_W-1:0] steps_b;
    logic             gnt_b;
    logic             up_down;
    logic             step;
    logic             busy;
    logic             owner;
    logic             done;
    logic [1:0]       pos;

    // Requester/system side
    modport master (
        output req_a, dir_a, steps_a, req_b, dir_b, steps_b,
        input  gnt_a, gnt_b, up_down, step, busy, owner, done, pos
    );

    // Arbiter side
    modport slave (
        input  req_a, dir_a, steps_a, req_b, dir_b, steps_b,
        output gnt_a, gnt_b, up_down, step, busy, owner, done, pos
    );
endinterface
`default_nettype wire

// File: rtl/count_step_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | count_step_arbiter                                               |
// | Round-robin sharing of a 2-bit up/down counter between two       |
// | requesters; optional macro STEP_GAP_EN inserts an idle cycle     |
// | between consecutive steps of a move.                             |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module count_step_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    count_step_arbiter_if.slave  bus
);
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;
`ifdef STEP_GAP_EN
    localparam logic [1:0] c_ST_GAP  = 2'd3;
`endif

    logic [1:0]       r_state;
    logic             r_prio;      // 0 = A has priority, 1 = B
    logic             r_owner;
    logic             r_dir_q;
    logic             r_gnt_a;
    logic             r_gnt_b;
    logic [CNT_W-1:0] r_remaining;
    logic [1:0]       r_pos;

    logic             w_any_req;
    logic             w_win_b;
    logic             w_win_dir;
    logic [CNT_W-1:0] w_win_steps;

    always_comb begin
        w_any_req   = bus.req_a | bus.req_b;
        w_win_b     = (bus.req_a && bus.req_b) ? r_prio : bus.req_b;
        w_win_dir   = w_win_b ? bus.dir_b   : bus.dir_a;
        w_win_steps = w_win_b ? bus.steps_b : bus.steps_a;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_prio      <= 1'b0;
            r_owner     <= 1'b0;
            r_dir_q     <= 1'b0;
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_remaining <= '0;
            r_pos       <= 2'd0;
        end else begin
            r_gnt_a <= 1'b0;
            r_gnt_b <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_req) begin
                        r_gnt_a     <= ~w_win_b;
                        r_gnt_b     <= w_win_b;
                        r_owner     <= w_win_b;
                        r_prio      <= ~w_win_b;
                        r_dir_q     <= w_win_dir;
                        r_remaining <= w_win_steps;
                        r_state     <= (w_win_steps == '0) ? c_ST_DONE : c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_remaining <= r_remaining - CNT_W'(1);
                    r_pos       <= r_dir_q ? (r_pos - 2'd1) : (r_pos + 2'd1);
                    if (r_remaining == CNT_W'(1)) begin
                        r_state <= c_ST_DONE;
                    end else begin
`ifdef STEP_GAP_EN
                        r_state <= c_ST_GAP;
`else
                        r_state <= c_ST_RUN;
`endif
                    end
                end
`ifdef STEP_GAP_EN
                c_ST_GAP:  r_state <= c_ST_RUN;
`endif
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    // All outputs are decoded from registers, so they are glitch-free to the counter
    assign bus.gnt_a   = r_gnt_a;
    assign bus.gnt_b   = r_gnt_b;
    assign bus.up_down = r_dir_q;
    assign bus.step    = (r_state == c_ST_RUN);
    assign bus.busy    = (r_state != c_ST_IDLE);
    assign bus.done    = (r_state == c_ST_DONE);
    assign bus.owner   = r_owner;
    assign bus.pos     = r_pos;
endmodule
`default_nettype wire

// File: tb/tb_count_step_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_count_step_arbiter                                            |
// | Self-checking bench with a move scoreboard checked at done.      |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_count_step_arbiter;
    logic clk;
    logic reset;

    typedef struct {
        logic       owner;
        logic       dir;
        int         steps;
        logic [1:0] pos;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         mon_steps = 0;
    logic [1:0] m_pos = 2'd0;

    count_step_arbiter_if #(.CNT_W(8)) bus ();

    count_step_arbiter #(.CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Per-cycle protocol checks and scoreboard pop on every done pulse
    always @(posedge clk) begin
        exp_t e;
        #1;
        n_tests++;
        if ((bus.gnt_a && bus.gnt_b) !== 1'b0) begin
            n_fail++;
            $display("FAIL dual_grant: actual gnt_a=%b gnt_b=%b required not both 1", bus.gnt_a, bus.gnt_b);
        end
        n_tests++;
        if ((bus.step && (bus.done || !bus.busy)) !== 1'b0) begin
            n_fail++;
            $display("FAIL step_outside_run: actual step=%b done=%b busy=%b required step=0", bus.step, bus.done, bus.busy);
        end
        if (bus.gnt_a || bus.gnt_b) mon_steps = bus.step ? 1 : 0;
        else if (bus.step)          mon_steps++;
        if (bus.done) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: actual done=1 required no pending move");
            end else begin
                e = sb.pop_front();
                if (bus.owner !== e.owner || mon_steps != e.steps || bus.pos !== e.pos || bus.up_down !== e.dir) begin
                    n_fail++;
                    $display("FAIL move_result: actual owner=%b steps=%0d pos=%0d up_down=%b required owner=%b steps=%0d pos=%0d up_down=%b",
                             bus.owner, mon_steps, bus.pos, bus.up_down, e.owner, e.steps, e.pos, e.dir);
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.req_a = 1'b0; bus.dir_a = 1'b0; bus.steps_a = 8'd0;
        bus.req_b = 1'b0; bus.dir_b = 1'b0; bus.steps_b = 8'd0;
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (bus.busy && k < limit);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: actual busy=%b required 0 within %0d cycles", bus.busy, limit);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.gnt_a, bus.gnt_b, bus.step, bus.busy, bus.done, bus.owner, bus.up_down, bus.pos} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: actual %b required 000000000",
                     {bus.gnt_a, bus.gnt_b, bus.step, bus.busy, bus.done, bus.owner, bus.up_down, bus.pos});
        end
        reset = 1'b0;
        m_pos = 2'd0;
        sb.delete();
    endtask

    task automatic test_move_up();
        bus.req_a = 1'b1; bus.dir_a = 1'b0; bus.steps_a = 8'd5;
        sb.push_back('{owner: 1'b0, dir: 1'b0, steps: 5, pos: 2'd1});
        @(posedge clk); #1;
        bus.req_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (bus.step !== 1'b1 || bus.up_down !== 1'b0 || bus.pos !== 2'(i) || bus.gnt_a !== (i == 0)) begin
                n_fail++;
                $display("FAIL move_up_step%0d: actual step=%b ud=%b pos=%0d gnt_a=%b required step=1 ud=0 pos=%0d gnt_a=%b",
                         i, bus.step, bus.up_down, bus.pos, bus.gnt_a, i % 4, (i == 0));
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (bus.done !== 1'b1 || bus.step !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL move_up_done: actual done=%b step=%b busy=%b required 1 0 1", bus.done, bus.step, bus.busy);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL move_up_idle: actual busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        m_pos = 2'd1;
    endtask

    task automatic test_move_down_wrap();
        logic [1:0] exp_pos [4];
        exp_pos[0] = 2'd0; exp_pos[1] = 2'd3; exp_pos[2] = 2'd2; exp_pos[3] = 2'd1;
        bus.req_b = 1'b1; bus.dir_b = 1'b1; bus.steps_b = 8'd3;
        sb.push_back('{owner: 1'b1, dir: 1'b1, steps: 3, pos: 2'd1});
        @(posedge clk); #1;
        bus.req_b = 1'b0;
        n_tests++;
        if (bus.gnt_b !== 1'b1 || bus.gnt_a !== 1'b0 || bus.owner !== 1'b1) begin
            n_fail++;
            $display("FAIL down_grant: actual gnt_b=%b gnt_a=%b owner=%b required 1 0 1", bus.gnt_b, bus.gnt_a, bus.owner);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (bus.pos !== exp_pos[i] || bus.step !== (i < 3) || bus.up_down !== 1'b1) begin
                n_fail++;
                $display("FAIL down_cycle%0d: actual pos=%0d step=%b ud=%b required pos=%0d step=%b ud=1",
                         i, bus.pos, bus.step, bus.up_down, exp_pos[i], (i < 3));
            end
            @(posedge clk); #1;
        end
        m_pos = 2'd1;
        wait_idle(5);
    endtask

    task automatic test_contention();
        int order[$];
        int k;
        bus.req_a = 1'b1; bus.dir_a = 1'b0; bus.steps_a = 8'd2;
        bus.req_b = 1'b1; bus.dir_b = 1'b1; bus.steps_b = 8'd3;
        sb.push_back('{owner: 1'b0, dir: 1'b0, steps: 2, pos: 2'd2});
        sb.push_back('{owner: 1'b1, dir: 1'b1, steps: 3, pos: 2'd3});
        sb.push_back('{owner: 1'b0, dir: 1'b0, steps: 2, pos: 2'd1});
        k = 0;
        while (order.size() < 3 && k < 60) begin
            @(posedge clk); #1;
            k++;
            if (bus.gnt_a) order.push_back(0);
            if (bus.gnt_b) order.push_back(1);
        end
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        n_tests++;
        if (order.size() != 3) begin
            n_fail++;
            $display("FAIL contention_count: actual %0d grants required 3", order.size());
        end else if (order[0] != 0 || order[1] != 1 || order[2] != 0) begin
            n_fail++;
            $display("FAIL contention_order: actual %0d,%0d,%0d required 0,1,0", order[0], order[1], order[2]);
        end
        wait_idle(20);
        m_pos = 2'd1;
    endtask

    task automatic test_zero_steps();
        bus.req_a = 1'b1; bus.dir_a = 1'b1; bus.steps_a = 8'd0;
        sb.push_back('{owner: 1'b0, dir: 1'b1, steps: 0, pos: m_pos});
        @(posedge clk); #1;
        bus.req_a = 1'b0;
        n_tests++;
        if (bus.gnt_a !== 1'b1 || bus.done !== 1'b1 || bus.step !== 1'b0 || bus.pos !== m_pos) begin
            n_fail++;
            $display("FAIL zero_steps: actual gnt_a=%b done=%b step=%b pos=%0d required 1 1 0 %0d",
                     bus.gnt_a, bus.done, bus.step, bus.pos, m_pos);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.pos !== m_pos) begin
            n_fail++;
            $display("FAIL zero_idle: actual busy=%b pos=%0d required 0 %0d", bus.busy, bus.pos, m_pos);
        end
    endtask

    task automatic test_reset_mid_move();
        int seen;
        int k;
        bus.req_a = 1'b1; bus.dir_a = 1'b0; bus.steps_a = 8'd10;
        @(posedge clk); #1;
        bus.req_a = 1'b0;
        seen = bus.step ? 1 : 0;
        k = 0;
        while (seen < 4 && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (bus.step) seen++;
        end
        n_tests++;
        if (seen != 4) begin
            n_fail++;
            $display("FAIL mid_steps_seen: actual %0d required 4", seen);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_tests++;
        if (bus.step !== 1'b0 || bus.busy !== 1'b0 || bus.pos !== 2'd0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: actual step=%b busy=%b pos=%0d done=%b required 0 0 0 0",
                     bus.step, bus.busy, bus.pos, bus.done);
        end
        repeat (12) @(posedge clk);
        #1;
        m_pos = 2'd0;
        bus.req_a = 1'b1; bus.dir_a = 1'b0; bus.steps_a = 8'd1;
        bus.req_b = 1'b1; bus.dir_b = 1'b1; bus.steps_b = 8'd2;
        sb.push_back('{owner: 1'b0, dir: 1'b0, steps: 1, pos: 2'd1});
        @(posedge clk); #1;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        n_tests++;
        if (bus.gnt_a !== 1'b1 || bus.gnt_b !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_prio: actual gnt_a=%b gnt_b=%b required 1 0", bus.gnt_a, bus.gnt_b);
        end
        wait_idle(10);
        m_pos = 2'd1;
    endtask

`ifdef STEP_GAP_EN
    task automatic test_step_gap();
        logic pat [6];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0; pat[4] = 1'b1; pat[5] = 1'b0;
        bus.req_a = 1'b1; bus.dir_a = 1'b0; bus.steps_a = 8'd3;
        sb.push_back('{owner: 1'b0, dir: 1'b0, steps: 3, pos: 2'd3});
        @(posedge clk); #1;
        bus.req_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (bus.step !== pat[i] || bus.done !== (i == 5)) begin
                n_fail++;
                $display("FAIL gap_cycle%0d: actual step=%b done=%b required step=%b done=%b",
                         i, bus.step, bus.done, pat[i], (i == 5));
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_idle: actual busy=%b required 0", bus.busy);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
`ifdef STEP_GAP_EN
        test_step_gap();
        test_reset();
`else
        test_move_up();
        test_reset();
        test_move_down_wrap();
`endif
        test_reset();
        test_contention();
        test_zero_steps();
        test_reset_mid_move();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual %0d pending required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
